// File: rtl/fft_pkg.sv
// Shared FFT definitions: data width, address-width helper, bit reversal, streamer states.
// No ports; imported by the result streamer, its interface and the input loader.
// bitrev() is width-generic up to 32 bits so both address generators can share it.
package fft_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  // Address width for an n-word memory; never below one bit.
  function automatic int calc_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Reverse the low w bits of v; bits above w come back as zero.
  // Shifts instead of indexing so the loop needs no run-time bit selects.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] src;
    logic [31:0] r;
    src = v;
    r   = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        r   = {r[30:0], src[0]};
        src = src >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_result_streamer_if.sv
// Bundle for the result streamer: control (start/busy/done), memory read port, output stream.
// master: the streamer drives busy, done, rd_addr, m_valid, m_data, m_last.
// slave: the environment drives start, rd_data (memory) and m_ready (sink).
interface fft_result_streamer_if #(
  parameter int N = 4096
);
  import fft_pkg::*;

  localparam int AW = calc_aw(N);

  logic              start;
  logic              busy;
  logic              done;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    input  start, rd_data, m_ready,
    output busy, done, rd_addr, m_valid, m_data, m_last
  );

  modport slave (
    output start, rd_data, m_ready,
    input  busy, done, rd_addr, m_valid, m_data, m_last
  );

endinterface

// File: rtl/fft_skid_fifo.sv
// Two-entry first-in first-out buffer holding {last, data} words behind the memory read port.
// Ports: clk, rst (async high); push_i/push_dat_i write; pop_i retires the head;
// head_dat_o shows the oldest entry, count_o its occupancy (0..2). Push+pop together keeps count.
module fft_skid_fifo #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] ent_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // When full, a push is only accepted alongside a pop (the slot being vacated).
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    if (do_push && !do_pop) count_d = count_q + 2'd1;
    if (!do_push && do_pop) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) ent_q[wr_ptr_q] <= push_dat_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat_o = ent_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/fft_result_streamer.sv
// Streams one N-word FFT frame from the result memory as valid/ready beats, m_last on word N-1.
// Ports: clk, rst (async high); bus (master): start/busy/done control, rd_addr/rd_data memory
// port (1-cycle read latency), m_valid/m_ready/m_data/m_last output stream.
// Define FFT_STREAM_BITREV_EN to read addresses in bit-reversed order (natural-order output
// for in-place results); default build reads linearly.
module fft_result_streamer
  import fft_pkg::*;
#(
  parameter int N = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  fft_result_streamer_if.master bus
);

  localparam int            AW       = calc_aw(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   k_q, k_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic            inflight_q, inflight_d;
  logic            infl_last_q, infl_last_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [1:0]      count;
  logic [DATA_W:0] head;
  logic            m_valid;
  logic            pop;
  logic            issue;

  function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] k);
`ifdef FFT_STREAM_BITREV_EN
    return AW'(bitrev(32'(k), AW));
`else
    return k;
`endif
  endfunction

  assign m_valid = (count != 2'd0);
  assign pop     = m_valid & bus.m_ready;

  // Issue only if the word would have a buffer slot when it lands:
  // count + inflight - pop < 2, rearranged so nothing underflows.
  // m_ready reaches issue combinationally; that is what keeps one word per cycle.
  assign issue = (state_q == RUN) &&
                 (({1'b0, count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    rd_addr_d   = rd_addr_q;
    inflight_d  = issue;
    infl_last_d = infl_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (issue) begin
      rd_addr_d   = addr_of(k_q);
      k_d         = k_q + AW'(1);
      // The last flag follows the index, not the address, so it holds in either order.
      infl_last_d = (k_q == LAST_IDX);
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          k_d     = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (issue && (k_q == LAST_IDX)) state_d = DRAIN;
      end
      DRAIN: begin
        // The last-flagged word is the final read, so once it is handshaken the
        // buffer is empty and nothing is in flight.
        if (pop && head[DATA_W]) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      rd_addr_q   <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      rd_addr_q   <= rd_addr_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  fft_skid_fifo #(
    .W (DATA_W + 1)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (inflight_q),
    .push_dat_i ({infl_last_q, bus.rd_data}),
    .pop_i      (pop),
    .head_dat_o (head),
    .count_o    (count)
  );

  // While idle in RUN the address holds, so the memory harmlessly re-reads it.
  assign bus.rd_addr = rd_addr_d;
  assign bus.m_valid = m_valid;
  assign bus.m_data  = head[DATA_W-1:0];
  assign bus.m_last  = m_valid & head[DATA_W];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_fft_result_streamer.sv
// Bench for fft_result_streamer with N=8: memory model, frame-level scoreboard, directed scenarios.
// Ports: none; instantiates the interface, the DUT and a 1-cycle-latency memory.
// Expected beats come from the frame definition (word k = mem[addr(k)], last on k=N-1).
module tb_fft_result_streamer;

  localparam int N  = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_result_streamer_if #(.N(N)) bus ();

  fft_result_streamer #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [63:0] mem [N];

  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

  int          checks = 0;
  int          failures = 0;
  logic [64:0] exp_q [$];
  logic        busy_m, done_m;
  logic        prev_stall, prev_last;
  logic [63:0] prev_data;
  int          cyc_n, start_cyc, first_valid_cyc, first_beat_cyc, last_beat_cyc;
  int          tot_beats, done_seen;

  function automatic int tb_addr(input int k);
`ifdef FFT_STREAM_BITREV_EN
    int r;
    r = 0;
    for (int b = 0; b < AW; b++) if ((k & (1 << b)) != 0) r = r | (1 << (AW - 1 - b));
    return r;
`else
    return k;
`endif
  endfunction

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic preload_linear();
    for (int i = 0; i < N; i++) mem[i] = 64'h100 + 64'(i);
  endtask

  task automatic model_reset();
    exp_q.delete();
    busy_m     = 1'b0;
    done_m     = 1'b0;
    prev_stall = 1'b0;
  endtask

  // Called once per cycle, after inputs are settled and well away from the clock edge.
  task automatic monitor();
    logic [64:0]   e;
    logic [AW-1:0] a;
    logic          hs, hs_last;
    cyc_n++;
    chk1("fifo_count_le2", dut.u_fifo.count_o <= 2'd2, 1'b1);
    chk1("busy", bus.busy, busy_m);
    chk1("done", bus.done, done_m);
    if (bus.done === 1'b1) done_seen++;
    if (!busy_m) chk1("idle_valid", bus.m_valid, 1'b0);
    if (prev_stall) begin
      chk1("stall_valid", bus.m_valid, 1'b1);
      chk64("stall_data", bus.m_data, prev_data);
      chk1("stall_last", bus.m_last, prev_last);
    end
    if (bus.m_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc_n;
    hs      = (bus.m_valid === 1'b1) && (bus.m_ready === 1'b1);
    hs_last = 1'b0;
    if (hs) begin
      if (first_beat_cyc < 0) first_beat_cyc = cyc_n;
      last_beat_cyc = cyc_n;
      tot_beats++;
      if (exp_q.size() == 0) begin
        chk1("extra_beat", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk64("beat_data", bus.m_data, e[63:0]);
        chk1("beat_last", bus.m_last, e[64]);
        hs_last = e[64];
      end
    end
    prev_stall = (bus.m_valid === 1'b1) && (bus.m_ready !== 1'b1);
    prev_data  = bus.m_data;
    prev_last  = bus.m_last;
    // Expectations for the next cycle.
    done_m = hs_last;
    if (bus.start && !busy_m) begin
      busy_m          = 1'b1;
      start_cyc       = cyc_n;
      first_valid_cyc = -1;
      first_beat_cyc  = -1;
      for (int k = 0; k < N; k++) begin
        a = AW'(tb_addr(k));
        exp_q.push_back({(k == N - 1), mem[a]});
      end
    end else if (hs_last) begin
      busy_m = 1'b0;
    end
  endtask

  task automatic cyc(input logic rdy, input logic st);
    @(negedge clk);
    bus.m_ready = rdy;
    bus.start   = st;
    #1;
    monitor();
  endtask

  // Runs until the next done pulse; mode 0 = sink always ready, 1 = random ready.
  task automatic run_frame(input int mode, input bit start_on_done, input int budget);
    int d0, n;
    logic rdy;
    d0 = done_seen;
    n  = 0;
    while (done_seen == d0 && n < budget) begin
      rdy = (mode == 0) ? 1'b1 : 1'($urandom);
      cyc(rdy, start_on_done && done_m);
      n++;
    end
    chk1("frame_completes", done_seen != d0, 1'b1);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n;
    n = 0;
    while (tot_beats < target && n < budget) begin
      cyc(1'b1, 1'b0);
      n++;
    end
    chk1("beats_reached", tot_beats >= target, 1'b1);
  endtask

  initial begin
    int t0, d0;
    void'($urandom(32'd1234));
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.m_ready = 1'b0;
    bus.rd_data = '0;
    preload_linear();
    model_reset();
    cyc_n = 0; tot_beats = 0; done_seen = 0;
    start_cyc = 0; first_valid_cyc = -1; first_beat_cyc = -1; last_beat_cyc = 0;

    #12;
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk1("rst_valid", bus.m_valid, 1'b0);
    chk1("rst_last", bus.m_last, 1'b0);
    chk64("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
    chk64("rst_data", bus.m_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full-rate frame: first beat two edges after the accepting edge, N back-to-back beats.
    t0 = tot_beats;
    cyc(1'b1, 1'b1);
    run_frame(0, 1'b0, 40);
    chk64("lat_first_valid", 64'(first_valid_cyc - start_cyc), 64'd3);
    chk64("full_rate_span", 64'(last_beat_cyc - first_beat_cyc), 64'(N - 1));
    chk64("frame1_beats", 64'(tot_beats - t0), 64'(N));
    cyc(1'b1, 1'b0);

    // Random backpressure over random data.
    for (int i = 0; i < N; i++) mem[i] = {$urandom, $urandom};
    t0 = tot_beats;
    cyc(1'($urandom), 1'b1);
    run_frame(1, 1'b0, 300);
    chk64("rand_beats", 64'(tot_beats - t0), 64'(N));
    chk64("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    preload_linear();
    cyc(1'b1, 1'b0);

    // Sink stalled from start: two reads, then the address freezes with word 0 held.
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0);
      chk64("stall_rd_addr", 64'(bus.rd_addr), 64'(tb_addr(1)));
      chk1("stall_hold_valid", bus.m_valid, 1'b1);
      chk64("stall_hold_word0", bus.m_data, 64'h100 + 64'(tb_addr(0)));
    end
    run_frame(0, 1'b0, 40);
    chk64("resume_span", 64'(last_beat_cyc - first_beat_cyc), 64'(N - 1));
    cyc(1'b1, 1'b0);

    // Start re-pulsed mid-frame is ignored; start on the done cycle launches a second frame.
    t0 = tot_beats;
    d0 = done_seen;
    cyc(1'b1, 1'b1);
    wait_beats(t0 + 3, 20);
    cyc(1'b1, 1'b1);
    run_frame(0, 1'b1, 40);
    chk64("repulse_beats", 64'(tot_beats - t0), 64'(N));
    run_frame(0, 1'b0, 40);
    chk64("b2b_beats", 64'(tot_beats - t0), 64'(2 * N));
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
    chk64("b2b_done_count", 64'(done_seen - d0), 64'd2);

    // Asynchronous reset after beat 4 aborts the frame without a done pulse.
    t0 = tot_beats;
    d0 = done_seen;
    cyc(1'b1, 1'b1);
    wait_beats(t0 + 4, 20);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk1("arst_busy", bus.busy, 1'b0);
    chk1("arst_done", bus.done, 1'b0);
    chk1("arst_valid", bus.m_valid, 1'b0);
    chk1("arst_last", bus.m_last, 1'b0);
    chk64("arst_rd_addr", 64'(bus.rd_addr), 64'd0);
    chk64("arst_data", bus.m_data, 64'd0);
    model_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
    chk64("arst_no_done", 64'(done_seen - d0), 64'd0);
    t0 = tot_beats;
    cyc(1'b1, 1'b1);
    run_frame(0, 1'b0, 40);
    chk64("post_rst_beats", 64'(tot_beats - t0), 64'(N));
    chk64("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_result_streamer.md
Name: fft_result_streamer

Overview:
- Drains a completed FFT frame out of the 64-bit, N-deep result memory through one of its registered-address read ports.
- Presents the frame as a valid/ready stream with frame-end marking.
- Sits directly downstream of the result memory and hides its 1-cycle read latency under downstream backpressure, using a 2-entry buffer.
- Sustains one word per cycle when the sink is always ready.

Parameters:
N, 4096, frame length in words; power of two, >= 4; address width AW = $clog2(N)

Ports:
clk      input   1    single clock, rising edge
rst      input   1    asynchronous active-high reset
start    input   1    1-cycle pulse: begin streaming a frame; ignored while busy
busy     output  1    high from start acceptance until final beat handshake
done     output  1    1-cycle pulse the cycle after the final beat handshake
rd_addr  output  AW   read address to memory port; memory registers it, data valid next cycle
rd_data  input   64   memory read data for address presented previous cycle
m_valid  output  1    stream data valid
m_ready  input   1    stream sink ready
m_data   output  64   stream word, passed through unmodified
m_last   output  1    high on the beat carrying word index N-1

Behaviour:
- Reset values: busy=0, done=0, m_valid=0, m_last=0, rd_addr=0, m_data=0. Reset also clears the issue counter, in-flight flag and buffer.
- Reset mid-frame aborts the frame; no done pulse is generated.
- States:
  - IDLE: start=1 -> RUN, issue counter k=0, busy=1.
  - RUN: issue reads while k<N. After the read for k=N-1 is issued -> DRAIN.
  - DRAIN: wait until the buffer is empty and nothing is in flight after the m_last handshake -> IDLE. done=1 for exactly the next cycle; busy=0 in that same cycle.
- Issue rule: a read for index k issues in cycle t iff
  - state=RUN, and
  - count + inflight - pop(t) < 2, where count = buffer occupancy (0..2), inflight = read issued in t-1, pop = m_valid & m_ready.
  - The m_ready -> issue combinational path is intended; it gives full throughput.
- On issue: rd_addr = addr(k), k increments, and inflight is set for t+1.
- In t+1, rd_data is pushed into the buffer. Push and pop in the same cycle are legal and leave count unchanged.
- Buffer: 2-entry FIFO, first-in first-out.
  - m_valid = count>0. m_data and m_last come from the head entry.
  - The last flag is captured with the index at issue time and travels with the data.
  - Overflow cannot occur by construction; a bench assertion checks count<=2.
- While not issuing, rd_addr holds its last value; the memory re-reads it, but the data is not pushed.
- m_data and m_last are held stable while m_valid=1 and m_ready=0.
- start while busy=1 is ignored with no side effects. start in the same cycle as done is accepted: busy goes high again next cycle.
- Latency with m_ready held high: first m_valid 2 cycles after start, N consecutive beats, done 1 cycle after the last beat.
- Words are passed through unchanged; no arithmetic on data.

Optional Feature:
- Macro: FFT_STREAM_BITREV_EN.
- Defined: addr(k) = bit-reverse of k over AW bits, so results computed in-place in bit-reversed order are emitted in natural order.
- Undefined: addr(k) = k (linear order).
- m_last always marks the N-th beat regardless of ordering.

Decomposition:
- Shared package fft_pkg:
  - DATA_W=64;
  - the AW computation helper;
  - bitrev function (width-generic, used by this block and the input loader);
  - state enum {IDLE, RUN, DRAIN}.
- One natural sub-module: fft_skid_fifo, a 2-entry FIFO (push/pop/count, 65-bit entries: data plus last), instanced once.

Test Plan:
- N=8, memory preloaded mem[i]=64'h100+i, macro undefined, m_ready=1, start pulse -> m_data 0x100..0x107 on 8 consecutive cycles; first beat 2 cycles after start; m_last only on 0x107; done 1 cycle later; busy low with done.
- N=8, FFT_STREAM_BITREV_EN defined, same preload -> output order 0x100,0x104,0x102,0x106,0x101,0x105,0x103,0x107; m_last on 0x107.
- N=8, m_ready pattern 1,0,0,1,1,0,1... (random, seed fixed) -> all 8 words in order, no loss or duplication; m_data stable during stalls; count never exceeds 2.
- m_ready=0 for 10 cycles after start -> exactly 2 reads issued, then rd_addr frozen; m_valid high with 0x100 held; on release, the stream resumes at full rate.
- start re-pulsed at beat 3 of a frame -> ignored; exactly 8 beats and one done. start on the done cycle -> second frame of 8 beats follows.
- rst asserted asynchronously after beat 4 -> all outputs 0 immediately; no done pulse; a new start after reset streams a complete frame from index 0.
